// File: rtl/score_display_mux.sv
// score_display_mux: snapshots converter BCD digits while IDLE and multiplexes them
// onto a 4-digit common-anode seven-segment display with leading-zero blanking and blink.
`default_nettype none

module score_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] conv_state,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [1:0]    CONV_IDLE  = 2'b00;

  logic [15:0]   snap_q, snap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic          blank;
  logic [3:0]    digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    tick          = (presc_q == PRESC_LAST);
    presc_d       = tick ? '0 : presc_q + PW'(1);
    idx_d         = tick ? idx_q + 2'd1 : idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    // Mid-conversion digits are shift/add intermediates; only IDLE values are captured.
    snap_d = (conv_state == CONV_IDLE) ? {bcd3, bcd2, bcd1, bcd0} : snap_q;

    digit = 4'd0;
    blank = 1'b0;
    case (idx_q)
      2'd0: digit = snap_q[3:0];
      2'd1: begin
        digit = snap_q[7:4];
        blank = blank_lz && (snap_q[15:4] == 12'h000);
      end
      2'd2: begin
        digit = snap_q[11:8];
        blank = blank_lz && (snap_q[15:8] == 8'h00);
      end
      default: begin
        digit = snap_q[15:12];
        blank = blank_lz && (snap_q[15:12] == 4'h0);
      end
    endcase

    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_decode(digit);
    if (blank || (blink_en && blink_phase_q)) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q        <= 16'h0000;
      presc_q       <= '0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= 4'b1110;
      seg_q         <= 7'b1000000;
    end else begin
      snap_q        <= snap_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

`default_nettype wire
